// File: rtl/rll_restore_ctrl.sv
// Sequential RLL-restore engine: one run-length marker per SCAN cycle, valid/ready on both sides.
// Define RLL_RESTORE_ERR_EN to enable malformed-marker detection on err; otherwise err is tied low.
module rll_restore_ctrl #(
   parameter int unsigned M     = 20,
   parameter int unsigned IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*M-1:0]   word_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*M-1:0]   word_out,
   output logic [6:0]       word_out_len,
   output logic             busy,
   output logic             err
);

   localparam int unsigned W  = 2 * M;
   localparam int unsigned PW = $clog2(W + 1);
   localparam int unsigned LW = 7;

`ifdef RLL_RESTORE_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t          state;
   logic [W-1:0]    work;
   logic [PW-1:0]   ptr;
   logic            err_q;

   logic [1:0]      flag;
   logic [IDX_W-1:0] idx;
   logic [W-1:0]    shifted;
   logic [W-1:0]    ins;
   logic            overrun;
   logic            idx_bad;
   logic            overlap;
   logic            field_oob;
   logic            chk_err;
   int              p;
   int              pos;
   int              len_i;

   // Marker decode and zero-pair re-insertion for the marker at ptr
   always_comb begin
      p         = int'(ptr);
      flag      = 2'(work >> ptr);
      idx       = IDX_W'(work >> (p + 2));
      pos       = int'(W) - 1 - 2 * int'(idx);
      overrun   = (p + 2) > (int'(W) - 2);
      idx_bad   = int'(idx) >= int'(M);
      overlap   = (pos - 3) < (p + int'(IDX_W) + 2);
      field_oob = (p + int'(IDX_W) + 2) > int'(W);
      chk_err   = ERR_EN && (idx_bad || overlap || field_oob);
      shifted   = work >> 4;
      ins       = work;
      for (int i = 0; i < int'(W); i++) begin
         if (i > pos)
            ins[i] = work[i];
         else if (i >= pos - 3)
            ins[i] = 1'b0;
         else if (i >= p + 2)
            ins[i] = shifted[i];
      end
      len_i = (int'(W) - p) / 2;
      if (len_i < 0)
         len_i = 0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         work         <= '0;
         ptr          <= '0;
         in_ready     <= 1'b0;
         out_valid    <= 1'b0;
         word_out     <= '0;
         word_out_len <= '0;
         busy         <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  work     <= word_in;
                  ptr      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  err_q    <= 1'b0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               if (overrun) begin
                  ptr   <= PW'(W);
                  err_q <= ERR_EN;
                  state <= DONE;
               end else if (flag == 2'b00) begin
                  ptr   <= ptr + PW'(2);
                  state <= DONE;
               end else if (chk_err) begin
                  err_q <= 1'b1;
                  state <= DONE;
               end else begin
                  // Out-of-range or overlapping markers are skipped when checks are disabled
                  if (!(idx_bad || overlap))
                     work <= ins;
                  ptr <= ptr + PW'(6);
               end
            end
            DONE: begin
               if (!out_valid) begin
                  word_out     <= work >> ptr;
                  word_out_len <= LW'(len_i);
                  out_valid    <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign err = ERR_EN ? err_q : 1'b0;

endmodule

// File: tb/tb_rll_restore_ctrl.sv
// Randomized self-checking bench for rll_restore_ctrl (M=20) against a word-level reference model.
module tb_rll_restore_ctrl;

   localparam int unsigned M = 20;
   localparam int unsigned W = 2 * M;

`ifdef RLL_RESTORE_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  word_in;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  word_out;
   logic [6:0]    word_out_len;
   logic          busy;
   logic          err;

   int n_checks = 0;
   int n_fail   = 0;

   rll_restore_ctrl #(.M(M), .IDX_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .word_in      (word_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .word_out     (word_out),
      .word_out_len (word_out_len),
      .busy         (busy),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] lowmask(input int n);
      return (64'd1 << n) - 64'd1;
   endfunction

   // Word-level restore: walk markers, splice four zero bits in at each target position
   function automatic void ref_model(input logic [W-1:0] w_in, output logic [W-1:0] w_exp,
                                     output int len_exp, output bit err_exp, output int scans);
      logic [63:0] w;
      int p, pf, idx, pos;
      bit done, bad;
      w = {24'd0, w_in};
      p = 0; pf = 0; err_exp = 1'b0; scans = 0; done = 1'b0;
      while (!done) begin
         scans++;
         if (p + 2 > 38) begin
            pf = 40; err_exp = ERR_EN; done = 1'b1;
         end else if (((w >> p) & 64'd3) == 64'd0) begin
            pf = p + 2; done = 1'b1;
         end else begin
            idx = int'((w >> (p + 2)) & 64'hff);
            pos = 39 - 2 * idx;
            bad = (idx >= 20) || (pos - 3 < p + 10);
            if (ERR_EN && (bad || p + 10 > 40)) begin
               pf = p; err_exp = 1'b1; done = 1'b1;
            end else begin
               if (!bad)
                  w = (w & ~lowmask(pos + 1))
                    | (((w >> (p + 6)) & lowmask(pos - p - 5)) << (p + 2))
                    | (w & lowmask(p + 2));
               p += 6;
            end
         end
      end
      w_exp   = W'(w >> pf);
      len_exp = (40 - pf) / 2;
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_wait", in_ready, 1);
   endtask

   task automatic run_word(input logic [W-1:0] w, input int hold, input int exp_lat);
      logic [W-1:0] w_exp;
      int len_exp, scans, lat;
      bit err_exp;
      ref_model(w, w_exp, len_exp, err_exp, scans);
      wait_ready();
      in_valid = 1'b1;
      word_in  = w;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("busy_after_accept", busy, 1);
      chk("in_ready_after_accept", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("out_valid_seen", out_valid, 1);
      chk("latency", lat, scans + 1);
      if (exp_lat >= 0)
         chk("latency_fixed", lat, exp_lat);
      chk("word_out", word_out, w_exp);
      chk("word_out_len", word_out_len, len_exp);
      chk("err", err, err_exp);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_out_valid", out_valid, 1);
         chk("hold_word_out", word_out, w_exp);
         chk("hold_len", word_out_len, len_exp);
         chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("out_valid_dropped", out_valid, 0);
      chk("in_ready_back", in_ready, 1);
      chk("busy_cleared", busy, 0);
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return W'(r);
   endfunction

   function automatic logic [W-1:0] marker_word();
      logic [W-1:0] w;
      w = rand_word();
      for (int g = 0; g < 5; g++) begin
         if ($urandom_range(0, 3) != 0) begin
            w[6*g +: 2]     = 2'($urandom_range(1, 3));
            w[6*g + 2 +: 8] = 8'($urandom_range(0, 19));
         end
      end
      return w;
   endfunction

   initial begin
      logic [W-1:0] w;
      rst_n = 1'b0; in_valid = 1'b0; word_in = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_word_out", word_out, 0);
      chk("rst_len", word_out_len, 0);
      @(negedge clk) rst_n = 1'b1;

      // no marker: single SCAN cycle
      w = rand_word(); w[1:0] = 2'b00;
      run_word(w, 0, 2);
      // one marker, idx 2
      w = rand_word(); w[1:0] = 2'b01; w[9:2] = 8'h02; w[11:10] = 2'b00;
      run_word(w, 0, 3);
      // three chained markers, idx 0 each
      w = rand_word();
      w[1:0] = 2'b01; w[9:2] = 8'h00; w[11:10] = 2'b01; w[19:12] = 8'h00;
      w[21:20] = 2'b01; w[29:22] = 8'h00; w[31:30] = 2'b00;
      run_word(w, 0, 5);
      // backpressure held for 10 cycles
      run_word(marker_word(), 10, -1);
      // out-of-range index
      w = rand_word(); w[1:0] = 2'b01; w[9:2] = 8'd25; w[11:10] = 2'b00;
      run_word(w, 0, ERR_EN ? 2 : -1);
      // every flag nonzero: pointer overrun
      w = '1;
      run_word(w, 0, -1);

      // reset pulsed mid-SCAN
      wait_ready();
      in_valid = 1'b1; word_in = marker_word();
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_word_out", word_out, 0);
      chk("midrst_len", word_out_len, 0);
      chk("midrst_err", err, 0);
      @(negedge clk) rst_n = 1'b1;
      w = rand_word(); w[1:0] = 2'b01; w[9:2] = 8'h05; w[11:10] = 2'b00;
      run_word(w, 0, 3);

      for (int t = 0; t < 300; t++) begin
         if (t % 2 == 0)
            run_word(rand_word(), $urandom_range(0, 2), -1);
         else
            run_word(marker_word(), $urandom_range(0, 2), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
